// File: rtl/bcd_display_scan_pkg.sv
// rtl/bcd_display_scan_pkg.sv - shared types and segment constants for the display scanner
// Package disp_pkg: segment patterns (active-low, gfedcba), digit-index type, page enum,
// and the packed shadow of the nine BCD inputs.
package disp_pkg;

    typedef logic [2:0] digit_idx_t;

    typedef enum logic {
        PAGE_TIME = 1'b0,
        PAGE_DATE = 1'b1
    } page_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef struct packed {
        logic [3:0] sec0;
        logic [3:0] sec1;
        logic [3:0] min0;
        logic [3:0] min1;
        logic [3:0] hour0;
        logic [3:0] hour1;
        logic [3:0] day0;
        logic [3:0] day1;
        logic [3:0] month;
    } bcd_shadow_t;

endpackage

// File: rtl/bcd_display_scan_if.sv
// rtl/bcd_display_scan_if.sv - signal bundle between the calendar/control side and the scanner
// master: drives Enable, page_next and the BCD digits; observes seg, dp, an, page.
// slave:  the scanner side (bcd_display_scan).
interface bcd_display_scan_if;
    logic       Enable;
    logic       page_next;
    logic [3:0] secbcd0;
    logic [3:0] secbcd1;
    logic [3:0] minbcd0;
    logic [3:0] minbcd1;
    logic [3:0] hourbcd0;
    logic [3:0] hourbcd1;
    logic [3:0] daybcd0;
    logic [3:0] daybcd1;
    logic [3:0] monthbcd;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic       page;

    modport master (
        output Enable, page_next, secbcd0, secbcd1, minbcd0, minbcd1,
               hourbcd0, hourbcd1, daybcd0, daybcd1, monthbcd,
        input  seg, dp, an, page
    );

    modport slave (
        input  Enable, page_next, secbcd0, secbcd1, minbcd0, minbcd1,
               hourbcd0, hourbcd1, daybcd0, daybcd1, monthbcd,
        output seg, dp, an, page
    );
endinterface

// File: rtl/bcd_display_scan_bcd_to_seg.sv
// rtl/bcd_display_scan_bcd_to_seg.sv - combinational 4-bit value to 7-segment decoder
// Ports: val_i (4-bit digit), blank_i (force all segments off), seg_o (gfedcba, active-low).
// Values 10..15 render as a dash.
module bcd_to_seg (
    input  logic [3:0] val_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);
    import disp_pkg::*;

    always_comb begin
        seg_o = SEG_DASH;
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end else if (val_i <= 4'd9) begin
            seg_o = SEG_DIGIT[val_i];
        end
    end
endmodule

// File: rtl/bcd_display_scan.sv
// rtl/bcd_display_scan.sv - 6-digit multiplexed 7-segment scanner with time/date pages
// Ports: clock, reset (async active-low), bus (bcd_display_scan_if.slave: Enable, page_next,
// nine BCD digits in; registered active-low seg/dp/an and the current page out).
// Optional macro DISP_BLINK_EN: separator dps follow shadow secbcd0[0] (blink) instead of steady.
module bcd_display_scan #(
    parameter int SCAN_DIV   = 50000,
    parameter int NUM_DIGITS = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    bcd_display_scan_if.slave    bus
);
    import disp_pkg::*;

    localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);
    localparam digit_idx_t  LAST_IDX   = digit_idx_t'(NUM_DIGITS - 1);

    logic [15:0] presc_q, presc_d;
    digit_idx_t  idx_q, idx_d;
    bcd_shadow_t shadow_q, shadow_d;
    logic        pending_q, pending_d;
    logic        started_q, started_d;
    page_e       page_q, page_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic [5:0]  an_q, an_d;

    logic        tick, boundary, lit;
    logic [3:0]  digit_val;
    logic        digit_blank, dp_sel, sep_dp;
    logic [6:0]  dec_seg;

    assign tick = bus.Enable && (presc_q == PRESC_LAST);
    // The first tick after reset opens the first frame: it loads the shadow without
    // advancing the index, so index 0 is the first digit lit and shows live inputs.
    assign boundary = tick && (!started_q || idx_q == LAST_IDX);
    assign lit = bus.Enable && started_q;

`ifdef DISP_BLINK_EN
    assign sep_dp = shadow_q.sec0[0];
`else
    assign sep_dp = 1'b0;
`endif

    always_comb begin
        digit_val   = 4'd0;
        digit_blank = 1'b1;
        dp_sel      = 1'b1;
        if (page_q == PAGE_TIME) begin
            digit_blank = 1'b0;
            case (idx_q)
                3'd0: digit_val = shadow_q.sec0;
                3'd1: digit_val = shadow_q.sec1;
                3'd2: digit_val = shadow_q.min0;
                3'd3: digit_val = shadow_q.min1;
                3'd4: digit_val = shadow_q.hour0;
                3'd5: begin
                    digit_val   = shadow_q.hour1;
                    digit_blank = (shadow_q.hour1 == 4'd0);
                end
                default: digit_blank = 1'b1;
            endcase
            if (idx_q == 3'd2 || idx_q == 3'd4) begin
                dp_sel = sep_dp;
            end
        end else begin
            case (idx_q)
                3'd0: begin digit_val = shadow_q.month; digit_blank = 1'b0; end
                3'd4: begin digit_val = shadow_q.day0;  digit_blank = 1'b0; end
                3'd5: begin digit_val = shadow_q.day1;  digit_blank = 1'b0; end
                default: digit_blank = 1'b1;
            endcase
        end
    end

    bcd_to_seg u_dec (
        .val_i   (digit_val),
        .blank_i (digit_blank),
        .seg_o   (dec_seg)
    );

    always_comb begin
        presc_d   = presc_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        started_d = started_q;
        page_d    = page_q;
        pending_d = pending_q | bus.page_next;

        if (bus.Enable) begin
            presc_d = tick ? 16'd0 : presc_q + 16'd1;
            if (tick && started_q) begin
                idx_d = (idx_q == LAST_IDX) ? digit_idx_t'(0) : idx_q + digit_idx_t'(1);
            end
            if (boundary) begin
                shadow_d  = '{sec0: bus.secbcd0, sec1: bus.secbcd1,
                              min0: bus.minbcd0, min1: bus.minbcd1,
                              hour0: bus.hourbcd0, hour1: bus.hourbcd1,
                              day0: bus.daybcd0, day1: bus.daybcd1,
                              month: bus.monthbcd};
                started_d = 1'b1;
                // A request arriving on the boundary cycle itself still counts.
                if (pending_q || bus.page_next) begin
                    page_d = (page_q == PAGE_TIME) ? PAGE_DATE : PAGE_TIME;
                end
                pending_d = 1'b0;
            end
        end

        an_d  = lit ? ~(6'b000001 << idx_q) : 6'b111111;
        seg_d = lit ? dec_seg : SEG_BLANK;
        dp_d  = lit ? dp_sel : 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_q   <= 16'd0;
            idx_q     <= digit_idx_t'(0);
            shadow_q  <= '0;
            started_q <= 1'b0;
            pending_q <= 1'b0;
            page_q    <= PAGE_TIME;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
            an_q      <= 6'b111111;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            started_q <= started_d;
            pending_q <= pending_d;
            page_q    <= page_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
        end
    end

    assign bus.seg  = seg_q;
    assign bus.dp   = dp_q;
    assign bus.an   = an_q;
    assign bus.page = page_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// tb/tb_bcd_display_scan.sv - directed self-checking bench for bcd_display_scan (SCAN_DIV = 4)
module tb_bcd_display_scan;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DA = 7'b0111111;
    localparam logic [5:0] DP_TIME = 6'b101011;
    localparam logic [5:0] DP_NONE = 6'b111111;

    bcd_display_scan_if bus ();

    bcd_display_scan #(.SCAN_DIV(4), .NUM_DIGITS(6)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return DA;
        endcase
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic dig(input int wait_c, input string tag, input int idx,
                       input logic [6:0] s, input logic d);
        logic [5:0] an_exp;
        cyc(wait_c);
        an_exp = ~(6'b000001 << idx);
        chk($sformatf("%s_d%0d_an", tag, idx), bus.an, an_exp);
        chk($sformatf("%s_d%0d_seg", tag, idx), bus.seg, s);
        chk($sformatf("%s_d%0d_dp", tag, idx), bus.dp, d);
    endtask

    // s packs the six expected patterns, index 0 in the low 7 bits.
    task automatic frame(input int first_wait, input string tag,
                         input logic [41:0] s, input logic [5:0] dpx);
        for (int i = 0; i < 6; i++) begin
            dig((i == 0) ? first_wait : 4, tag, i, s[7*i +: 7], dpx[i]);
        end
    endtask

    task automatic set_time(input int h1, input int h0, input int m1, input int m0,
                            input int s1, input int s0);
        bus.hourbcd1 = 4'(h1); bus.hourbcd0 = 4'(h0);
        bus.minbcd1  = 4'(m1); bus.minbcd0  = 4'(m0);
        bus.secbcd1  = 4'(s1); bus.secbcd0  = 4'(s0);
    endtask

    task automatic set_date(input int d1, input int d0, input int mo);
        bus.daybcd1 = 4'(d1); bus.daybcd0 = 4'(d0); bus.monthbcd = 4'(mo);
    endtask

    initial begin
        bus.Enable = 1'b1;
        bus.page_next = 1'b0;
        set_time(1, 2, 3, 4, 5, 6);
        set_date(0, 1, 1);

        cyc(2);
        chk("rst_an", bus.an, 6'b111111);
        chk("rst_seg", bus.seg, BL);
        chk("rst_dp", bus.dp, 1'b1);
        chk("rst_page", bus.page, 1'b0);

        reset = 1'b1;
        cyc(3);
        chk("pre_tick_an", bus.an, 6'b111111);
        frame(2, "f1", {enc(1), enc(2), enc(3), enc(4), enc(5), enc(6)}, DP_TIME);

        // Mid-frame input change must not leak into the current frame.
        set_time(1, 2, 3, 4, 5, 9);
        dig(4, "f2", 0, enc(9), 1'b1);
        set_time(1, 2, 3, 5, 0, 0);
        dig(4, "f2", 1, enc(5), 1'b1);
        dig(4, "f2", 2, enc(4), 1'b0);
        dig(4, "f2", 3, enc(3), 1'b1);
        dig(4, "f2", 4, enc(2), 1'b0);
        dig(4, "f2", 5, enc(1), 1'b1);
        frame(4, "f3", {enc(1), enc(2), enc(3), enc(5), enc(0), enc(0)}, DP_TIME);

        // Leading-zero hour, plus three page requests within one frame.
        set_time(0, 9, 0, 5, 0, 0);
        dig(4, "f4", 0, enc(0), 1'b1);
        set_date(2, 7, 3);
        bus.page_next = 1'b1; cyc(1); bus.page_next = 1'b0; cyc(1);
        bus.page_next = 1'b1; cyc(1); bus.page_next = 1'b0;
        dig(1, "f4", 1, enc(0), 1'b1);
        chk("f4_page_held", bus.page, 1'b0);
        bus.page_next = 1'b1; cyc(1); bus.page_next = 1'b0;
        dig(3, "f4", 2, enc(5), 1'b0);
        dig(4, "f4", 3, enc(0), 1'b1);
        dig(4, "f4", 4, enc(9), 1'b0);
        dig(4, "f4", 5, BL, 1'b1);

        frame(4, "f5_date", {enc(2), enc(7), BL, BL, BL, enc(3)}, DP_NONE);
        chk("f5_page", bus.page, 1'b1);

        // Request landing exactly on the boundary edge toggles there.
        cyc(2);
        bus.page_next = 1'b1; cyc(1); bus.page_next = 1'b0;
        dig(1, "f6", 0, enc(0), 1'b1);
        chk("f6_page", bus.page, 1'b0);

        // Enable low for 10 cycles mid-digit, then resume with remaining count.
        bus.Enable = 1'b0;
        cyc(1);
        chk("dis_an_first", bus.an, 6'b111111);
        cyc(9);
        chk("dis_an_last", bus.an, 6'b111111);
        bus.Enable = 1'b1;
        cyc(1);
        chk("en_resume_an", bus.an, 6'b111110);
        cyc(2);
        chk("en_hold_an", bus.an, 6'b111110);
        cyc(1);
        chk("en_next_an", bus.an, 6'b111101);

        // Reach page 1, leave a toggle pending, then reset asynchronously.
        bus.page_next = 1'b1; cyc(1); bus.page_next = 1'b0;
        cyc(19);
        chk("pre_rst_page", bus.page, 1'b1);
        bus.page_next = 1'b1; cyc(1); bus.page_next = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_rst_page", bus.page, 1'b0);
        chk("async_rst_an", bus.an, 6'b111111);
        chk("async_rst_seg", bus.seg, BL);
        set_time(1, 12, 3, 4, 5, 6);
        cyc(2);
        reset = 1'b1;
        frame(5, "f_rst", {enc(1), DA, enc(3), enc(4), enc(5), enc(6)}, DP_TIME);
        chk("post_rst_page_a", bus.page, 1'b0);
        cyc(4);
        chk("post_rst_page_b", bus.page, 1'b0);
        chk("post_rst_wrap_an", bus.an, 6'b111110);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
